mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; data width SHALL be 64 bits (REG_BUS), address width 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  EX stage presents an op.
REQ-005 ex_ready  output  1  stage accepts op this cycle.
REQ-006 mem_r_ena / mem_w_ena / mem_ext_un / mem_to_reg  input  1 each  decode controls (load, store, unsigned load, load writeback).
REQ-007 byte_enable  input  8  unshifted access mask (0x01/0x03/0x0F/0xFF).
REQ-008 addr  input  64  ALU result: effective address, or writeback value for non-memory ops.
REQ-009 store_data  input  64  rs2 value, LSB-justified.
REQ-010 rd_w_addr  input  5 ; rd_w_ena  input  1  destination register control.
REQ-011 dbus_valid  output  1 ; dbus_ready  input  1  data-bus request handshake.
REQ-012 dbus_we  output  1 ; dbus_addr  output  64 ; dbus_wstrb  output  8 ; dbus_wdata  output  64  request payload.
REQ-013 dbus_rvalid  input  1 ; dbus_rdata  input  64  read response.
REQ-014 wb_valid  output  1 ; wb_rd_ena  output  1 ; wb_rd_addr  output  5 ; wb_data  output  64  writeback result.

Function
REQ-015 FSM states: IDLE, REQ, RESP; ex_ready SHALL be 1 only in IDLE with rst low.
REQ-016 Accept = ex_valid & ex_ready; on accept, all inputs SHALL be captured into registers.
REQ-017 Non-memory op (mem_r_ena=0, mem_w_ena=0, or byte_enable=0): stay IDLE; next cycle wb_valid=1, wb_data=addr, wb_rd_ena=rd_w_ena, wb_rd_addr=rd_w_addr.
REQ-018 Memory op: next state REQ; dbus_valid=1, dbus_addr={addr[63:3],3'b0}, dbus_we=mem_w_ena, dbus_wstrb=(byte_enable<<addr[2:0]) truncated to 8 bits, dbus_wdata=store_data<<(8*addr[2:0]).
REQ-019 Request payload SHALL hold stable while dbus_valid & !dbus_ready.
REQ-020 REQ & dbus_ready, store: next state IDLE, dbus_valid=0; next cycle wb_valid=1, wb_rd_ena=0.
REQ-021 REQ & dbus_ready, load: next state RESP, dbus_valid=0.
REQ-022 dbus_rvalid SHALL be sampled only in RESP; ignored in IDLE/REQ.
REQ-023 RESP & dbus_rvalid: next state IDLE; next cycle wb_valid=1, wb_rd_ena=rd_w_ena, wb_data = (dbus_rdata>>(8*addr[2:0])) masked to access width, zero-extended if mem_ext_un else sign-extended from top byte of width.
REQ-024 wb_valid SHALL be a single-cycle pulse; no backpressure from WB.
REQ-025 Minimum latency accept->wb_valid: 1 cycle non-memory, 2 cycles store, 3 cycles load.
REQ-026 mem_r_ena & mem_w_ena both 1 SHALL be treated as store.
REQ-027 Without check, access crossing 8-byte boundary SHALL drop the upper lanes (truncation), no error.

Reset
REQ-028 On rst: state IDLE; dbus_valid, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata, wb_valid, wb_rd_ena, wb_rd_addr, wb_data, ex_ready SHALL be 0.
REQ-029 rst mid-transaction SHALL abandon it; dbus_valid 0 the next cycle; late dbus_rvalid SHALL not produce wb_valid.

Configuration
REQ-030 Macro MEM_MISALIGN_CHECK_EN defined: output misalign (1 bit, reset 0) exists; memory op with addr not a multiple of access size SHALL issue no bus request, stay IDLE, and next cycle pulse wb_valid=1, wb_rd_ena=0, misalign=1.
REQ-031 Macro undefined: port misalign absent; REQ-027 applies.

Structure
REQ-032 FSM state encodings, byte_enable width constants, REG_BUS SHALL live in the shared defines.v.
REQ-033 Sub-module mem_align (combinational: rdata shift, mask, sign/zero extend) SHALL be instantiated once.

Verification
REQ-034 LD addr=0x1000, rdata=0x1122334455667788, ready/rvalid immediate -> wb_data=0x1122334455667788 on 3rd cycle after accept.
REQ-035 LB addr=0x1003, rdata byte3=0x80 -> wb_data=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-036 SH addr=0x2006, store_data=0xBEEF -> dbus_addr=0x2000, wstrb=0xC0, wdata=0xBEEF<<48; dbus_ready held low 4 cycles -> payload stable.
REQ-037 ADD result 0x5 with rd_w_ena=1, rd=3 -> wb_valid next cycle, wb_data=5, wb_rd_addr=3; no dbus_valid.
REQ-038 rst asserted in RESP, then rvalid -> no wb_valid, state IDLE, ex_ready=1 after rst drops.
REQ-039 MEM_MISALIGN_CHECK_EN, LW addr=0x1002 -> no dbus_valid, misalign=1, wb_rd_ena=0 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage.
//   REG_BUS / ADDR_W     : data and address widths (64 bits)
//   BE_*                 : unshifted byte_enable patterns for byte/half/word/double
//   mem_state_e          : memory-stage FSM encodings
//   misaligned()         : true when an offset is not a multiple of the access size
package mem_stage_pkg;

    localparam int REG_BUS = 64;
    localparam int ADDR_W  = 64;

    localparam logic [7:0] BE_B = 8'h01;
    localparam logic [7:0] BE_H = 8'h03;
    localparam logic [7:0] BE_W = 8'h0F;
    localparam logic [7:0] BE_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    function automatic logic misaligned(input logic [2:0] off, input logic [7:0] be);
        logic bad;
        case (be)
            BE_H:    bad = off[0];
            BE_W:    bad = |off[1:0];
            BE_D:    bad = |off;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational load-data formatter.
//   rdata       : raw 64-bit doubleword from the data bus
//   offset      : byte offset of the access within the doubleword
//   byte_enable : unshifted access mask (selects 8/16/32/64-bit width)
//   ext_un      : 1 = zero-extend, 0 = sign-extend from the top byte of the width
//   data_out    : right-justified, extended load result
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [REG_BUS-1:0] rdata,
    input  logic [2:0]         offset,
    input  logic [7:0]         byte_enable,
    input  logic               ext_un,
    output logic [REG_BUS-1:0] data_out
);

    logic [REG_BUS-1:0] shifted;

    // Lanes above the doubleword shift in as zero, which is what truncates
    // an access that runs past the 8-byte boundary.
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data_out = shifted;
        case (byte_enable)
            BE_B: data_out = ext_un ? {56'd0, shifted[7:0]}
                                    : {{56{shifted[7]}}, shifted[7:0]};
            BE_H: data_out = ext_un ? {48'd0, shifted[15:0]}
                                    : {{48{shifted[15]}}, shifted[15:0]};
            BE_W: data_out = ext_un ? {32'd0, shifted[31:0]}
                                    : {{32{shifted[31]}}, shifted[31:0]};
            default: data_out = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage between EX and WB with a valid/ready data bus.
//   clk, rst (sync, active-high)
//   EX side   : ex_valid/ex_ready, mem_r_ena, mem_w_ena, mem_ext_un, mem_to_reg,
//               byte_enable, addr, store_data, rd_w_addr, rd_w_ena
//   data bus  : dbus_valid/dbus_ready, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
//               dbus_rvalid, dbus_rdata
//   WB side   : wb_valid (1-cycle pulse), wb_rd_ena, wb_rd_addr, wb_data
//   Optional  : MEM_MISALIGN_CHECK_EN adds output misalign and suppresses
//               bus requests for misaligned accesses.
//
// state   | meaning
// IDLE    | ready for a new op; non-memory ops complete from here
// REQ     | bus request outstanding, payload held until dbus_ready
// RESP    | load issued, waiting for dbus_rvalid
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               mem_r_ena,
    input  logic               mem_w_ena,
    input  logic               mem_ext_un,
    input  logic               mem_to_reg,
    input  logic [7:0]         byte_enable,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [REG_BUS-1:0] store_data,
    input  logic [4:0]         rd_w_addr,
    input  logic               rd_w_ena,
    output logic               dbus_valid,
    input  logic               dbus_ready,
    output logic               dbus_we,
    output logic [ADDR_W-1:0]  dbus_addr,
    output logic [7:0]         dbus_wstrb,
    output logic [REG_BUS-1:0] dbus_wdata,
    input  logic               dbus_rvalid,
    input  logic [REG_BUS-1:0] dbus_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic               misalign,
`endif
    output logic               wb_valid,
    output logic               wb_rd_ena,
    output logic [4:0]         wb_rd_addr,
    output logic [REG_BUS-1:0] wb_data
);

    mem_state_e state_q, state_d;

    logic [2:0]         off_q, off_d;
    logic [7:0]         be_q, be_d;
    logic               ext_un_q, ext_un_d;
    logic               is_store_q, is_store_d;
    logic               rd_w_ena_q, rd_w_ena_d;
    logic [4:0]         rd_w_addr_q, rd_w_addr_d;

    logic               dbus_valid_q, dbus_valid_d;
    logic               dbus_we_q, dbus_we_d;
    logic [ADDR_W-1:0]  dbus_addr_q, dbus_addr_d;
    logic [7:0]         dbus_wstrb_q, dbus_wstrb_d;
    logic [REG_BUS-1:0] dbus_wdata_q, dbus_wdata_d;

    logic               wb_valid_q, wb_valid_d;
    logic               wb_rd_ena_q, wb_rd_ena_d;
    logic [4:0]         wb_rd_addr_q, wb_rd_addr_d;
    logic [REG_BUS-1:0] wb_data_q, wb_data_d;

`ifdef MEM_MISALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
`endif

    logic               accept;
    logic               is_mem;
    logic               bad_align;
    logic [7:0]         wstrb_shift;
    logic [REG_BUS-1:0] wdata_shift;
    logic [REG_BUS-1:0] load_data;
    logic               unused_mem_to_reg;

    // Load writeback is governed by rd_w_ena; mem_to_reg carries no extra information here.
    assign unused_mem_to_reg = mem_to_reg;

    assign ex_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = (mem_r_ena || mem_w_ena) && (byte_enable != 8'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    assign bad_align = misaligned(addr[2:0], byte_enable);
`else
    assign bad_align = 1'b0;
`endif

    // 8-bit and 64-bit result widths drop lanes shifted past the doubleword.
    assign wstrb_shift = byte_enable << addr[2:0];
    assign wdata_shift = store_data << {addr[2:0], 3'b000};

    mem_align u_mem_align (
        .rdata       (dbus_rdata),
        .offset      (off_q),
        .byte_enable (be_q),
        .ext_un      (ext_un_q),
        .data_out    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            off_q        <= '0;
            be_q         <= '0;
            ext_un_q     <= 1'b0;
            is_store_q   <= 1'b0;
            rd_w_ena_q   <= 1'b0;
            rd_w_addr_q  <= '0;
            dbus_valid_q <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wstrb_q <= '0;
            dbus_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_ena_q  <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            be_q         <= be_d;
            ext_un_q     <= ext_un_d;
            is_store_q   <= is_store_d;
            rd_w_ena_q   <= rd_w_ena_d;
            rd_w_addr_q  <= rd_w_addr_d;
            dbus_valid_q <= dbus_valid_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_wstrb_q <= dbus_wstrb_d;
            dbus_wdata_q <= dbus_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_ena_q  <= wb_rd_ena_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mem && !bad_align) state_d = ST_REQ;
            ST_REQ:  if (dbus_ready) state_d = is_store_q ? ST_IDLE : ST_RESP;
            ST_RESP: if (dbus_rvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        off_d        = off_q;
        be_d         = be_q;
        ext_un_d     = ext_un_q;
        is_store_d   = is_store_q;
        rd_w_ena_d   = rd_w_ena_q;
        rd_w_addr_d  = rd_w_addr_q;
        dbus_valid_d = dbus_valid_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_wstrb_d = dbus_wstrb_q;
        dbus_wdata_d = dbus_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_ena_d  = wb_rd_ena_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_data_d    = wb_data_q;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    off_d       = addr[2:0];
                    be_d        = byte_enable;
                    ext_un_d    = mem_ext_un;
                    is_store_d  = mem_w_ena;
                    rd_w_ena_d  = rd_w_ena;
                    rd_w_addr_d = rd_w_addr;
                    if (!is_mem) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_ena_d  = rd_w_ena;
                        wb_rd_addr_d = rd_w_addr;
                        wb_data_d    = addr;
                    end else if (bad_align) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_ena_d  = 1'b0;
                        wb_rd_addr_d = rd_w_addr;
`ifdef MEM_MISALIGN_CHECK_EN
                        misalign_d   = 1'b1;
`endif
                    end else begin
                        dbus_valid_d = 1'b1;
                        dbus_we_d    = mem_w_ena;
                        dbus_addr_d  = {addr[ADDR_W-1:3], 3'b000};
                        dbus_wstrb_d = wstrb_shift;
                        dbus_wdata_d = wdata_shift;
                    end
                end
            end
            ST_REQ: begin
                if (dbus_ready) begin
                    dbus_valid_d = 1'b0;
                    if (is_store_q) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_ena_d  = 1'b0;
                        wb_rd_addr_d = rd_w_addr_q;
                    end
                end
            end
            ST_RESP: begin
                if (dbus_rvalid) begin
                    wb_valid_d   = 1'b1;
                    wb_rd_ena_d  = rd_w_ena_q;
                    wb_rd_addr_d = rd_w_addr_q;
                    wb_data_d    = load_data;
                end
            end
            default: ;
        endcase
    end

    assign dbus_valid = dbus_valid_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wstrb = dbus_wstrb_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd_ena  = wb_rd_ena_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_data    = wb_data_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change and outputs are sampled on the falling clock edge.
// Build with MEM_MISALIGN_CHECK_EN defined to cover the misalignment check.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        mem_r_ena, mem_w_ena, mem_ext_un, mem_to_reg;
    logic [7:0]  byte_enable;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [4:0]  rd_w_addr;
    logic        rd_w_ena;
    logic        dbus_valid, dbus_ready, dbus_we;
    logic [63:0] dbus_addr;
    logic [7:0]  dbus_wstrb;
    logic [63:0] dbus_wdata;
    logic        dbus_rvalid;
    logic [63:0] dbus_rdata;
    logic        wb_valid, wb_rd_ena;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .mem_r_ena   (mem_r_ena),
        .mem_w_ena   (mem_w_ena),
        .mem_ext_un  (mem_ext_un),
        .mem_to_reg  (mem_to_reg),
        .byte_enable (byte_enable),
        .addr        (addr),
        .store_data  (store_data),
        .rd_w_addr   (rd_w_addr),
        .rd_w_ena    (rd_w_ena),
        .dbus_valid  (dbus_valid),
        .dbus_ready  (dbus_ready),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wstrb  (dbus_wstrb),
        .dbus_wdata  (dbus_wdata),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .wb_valid    (wb_valid),
        .wb_rd_ena   (wb_rd_ena),
        .wb_rd_addr  (wb_rd_addr),
        .wb_data     (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one op at the current falling edge; returns one cycle after accept.
    task automatic drive_op(input logic r, input logic w, input logic un,
                            input logic [7:0] be, input logic [63:0] a,
                            input logic [63:0] sd, input logic [4:0] rd,
                            input logic rde);
        mem_r_ena   = r;
        mem_w_ena   = w;
        mem_ext_un  = un;
        mem_to_reg  = r & ~w;
        byte_enable = be;
        addr        = a;
        store_data  = sd;
        rd_w_addr   = rd;
        rd_w_ena    = rde;
        ex_valid    = 1'b1;
        @(negedge clk);
        ex_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; mem_r_ena = 1'b0; mem_w_ena = 1'b0;
        mem_ext_un = 1'b0; mem_to_reg = 1'b0; byte_enable = 8'h00; addr = '0;
        store_data = '0; rd_w_addr = '0; rd_w_ena = 1'b0; dbus_ready = 1'b0;
        dbus_rvalid = 1'b0; dbus_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ex_ready: got %h want 0", ex_ready); end
        checks++; if (dbus_valid !== 1'b0) begin errors++; $display("FAIL reset_dbus_valid: got %h want 0", dbus_valid); end
        checks++; if ({dbus_we, dbus_addr, dbus_wstrb, dbus_wdata} !== 137'd0) begin errors++; $display("FAIL reset_dbus_payload: we=%h addr=%h wstrb=%h wdata=%h want all 0", dbus_we, dbus_addr, dbus_wstrb, dbus_wdata); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %h want 0", wb_valid); end
        checks++; if ({wb_rd_ena, wb_rd_addr, wb_data} !== 70'd0) begin errors++; $display("FAIL reset_wb_fields: ena=%h rd=%h data=%h want all 0", wb_rd_ena, wb_rd_addr, wb_data); end
`ifdef MEM_MISALIGN_CHECK_EN
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %h want 0", misalign); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ex_ready: got %h want 1", ex_ready); end
        @(negedge clk);
    endtask

    task automatic test_nonmem();
        drive_op(1'b0, 1'b0, 1'b0, 8'h00, 64'h5, 64'h0, 5'd3, 1'b1);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %h want 1", wb_valid); end
        checks++; if (wb_data !== 64'h5) begin errors++; $display("FAIL add_wb_data: got %h want 5", wb_data); end
        checks++; if ({wb_rd_ena, wb_rd_addr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL add_wb_rd: ena=%h rd=%0d want ena=1 rd=3", wb_rd_ena, wb_rd_addr); end
        checks++; if (dbus_valid !== 1'b0) begin errors++; $display("FAIL add_no_dbus: got %h want 0", dbus_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_pulse: got %h want 0", wb_valid); end
        checks++; if (dbus_valid !== 1'b0) begin errors++; $display("FAIL add_no_dbus_later: got %h want 0", dbus_valid); end
    endtask

    task automatic test_load_ld();
        // rvalid held high from the start: it must be ignored until RESP.
        dbus_ready = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 64'h1122334455667788;
        drive_op(1'b1, 1'b0, 1'b0, 8'hFF, 64'h1000, 64'h0, 5'd7, 1'b1);
        checks++; if ({dbus_valid, dbus_we, dbus_addr} !== {1'b1, 1'b0, 64'h1000}) begin errors++; $display("FAIL ld_req: valid=%h we=%h addr=%h want 1 0 1000", dbus_valid, dbus_we, dbus_addr); end
        checks++; if (dbus_wstrb !== 8'hFF) begin errors++; $display("FAIL ld_wstrb: got %h want ff", dbus_wstrb); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_early_wb_c1: got %h want 0", wb_valid); end
        @(negedge clk);
        checks++; if ({dbus_valid, wb_valid} !== 2'b00) begin errors++; $display("FAIL ld_resp_wait: dbus_valid=%h wb_valid=%h want 0 0", dbus_valid, wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ld_wb_valid: got %h want 1", wb_valid); end
        checks++; if (wb_data !== 64'h1122334455667788) begin errors++; $display("FAIL ld_wb_data: got %h want 1122334455667788", wb_data); end
        checks++; if ({wb_rd_ena, wb_rd_addr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL ld_wb_rd: ena=%h rd=%0d want ena=1 rd=7", wb_rd_ena, wb_rd_addr); end
        dbus_rvalid = 1'b0; dbus_ready = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wb_pulse: got %h want 0", wb_valid); end
    endtask

    task automatic test_load_byte();
        logic [63:0] exp;
        for (int u = 0; u < 2; u++) begin
            exp = (u == 1) ? 64'h80 : 64'hFFFFFFFFFFFFFF80;
            dbus_ready = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 64'h0000000080000000;
            drive_op(1'b1, 1'b0, (u == 1), 8'h01, 64'h1003, 64'h0, 5'd4, 1'b1);
            checks++; if ({dbus_addr, dbus_wstrb} !== {64'h1000, 8'h08}) begin errors++; $display("FAIL lb_req u=%0d: addr=%h wstrb=%h want 1000 08", u, dbus_addr, dbus_wstrb); end
            @(negedge clk);
            @(negedge clk);
            checks++; if ({wb_valid, wb_data} !== {1'b1, exp}) begin errors++; $display("FAIL lb_wb u=%0d: valid=%h data=%h want 1 %h", u, wb_valid, wb_data, exp); end
            dbus_rvalid = 1'b0; dbus_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_load_word();
        dbus_ready = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 64'h8765432100000000;
        drive_op(1'b1, 1'b0, 1'b0, 8'h0F, 64'h1004, 64'h0, 5'd12, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({wb_valid, wb_data} !== {1'b1, 64'hFFFFFFFF87654321}) begin errors++; $display("FAIL lw_wb: valid=%h data=%h want 1 ffffffff87654321", wb_valid, wb_data); end
        dbus_rvalid = 1'b0; dbus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_stall();
        dbus_ready = 1'b0; dbus_rvalid = 1'b0;
        drive_op(1'b0, 1'b1, 1'b0, 8'h03, 64'h2006, 64'hBEEF, 5'd9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dbus_valid, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata} !==
                {1'b1, 1'b1, 64'h2000, 8'hC0, 64'hBEEF000000000000}) begin
                errors++;
                $display("FAIL sh_stall_payload c%0d: valid=%h we=%h addr=%h wstrb=%h wdata=%h want 1 1 2000 c0 beef000000000000",
                         i, dbus_valid, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata);
            end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sh_stall_wb c%0d: got %h want 0", i, wb_valid); end
            if (i == 3) dbus_ready = 1'b1;
            @(negedge clk);
        end
        dbus_ready = 1'b0;
        checks++; if ({dbus_valid, wb_valid, wb_rd_ena} !== 3'b010) begin errors++; $display("FAIL sh_done: dbus_valid=%h wb_valid=%h wb_rd_ena=%h want 0 1 0", dbus_valid, wb_valid, wb_rd_ena); end
        @(negedge clk);
    endtask

    task automatic test_store_fast();
        // Both enables set behaves as a store; two-cycle latency with ready high.
        dbus_ready = 1'b1;
        drive_op(1'b1, 1'b1, 1'b0, 8'h01, 64'h3001, 64'h5A, 5'd2, 1'b1);
        checks++; if ({dbus_we, dbus_wstrb, dbus_wdata} !== {1'b1, 8'h02, 64'h5A00}) begin errors++; $display("FAIL sb_req: we=%h wstrb=%h wdata=%h want 1 02 5a00", dbus_we, dbus_wstrb, dbus_wdata); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sb_early_wb: got %h want 0", wb_valid); end
        @(negedge clk);
        checks++; if ({wb_valid, wb_rd_ena, dbus_valid} !== 3'b100) begin errors++; $display("FAIL sb_wb: wb_valid=%h wb_rd_ena=%h dbus_valid=%h want 1 0 0", wb_valid, wb_rd_ena, dbus_valid); end
        dbus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mem_r_ena = 1'b0; mem_w_ena = 1'b0; byte_enable = 8'h00;
        rd_w_ena = 1'b1; rd_w_addr = 5'd1; addr = 64'h11; ex_valid = 1'b1;
        @(negedge clk);
        checks++; if ({wb_valid, wb_data, wb_rd_addr} !== {1'b1, 64'h11, 5'd1}) begin errors++; $display("FAIL b2b_first: valid=%h data=%h rd=%0d want 1 11 1", wb_valid, wb_data, wb_rd_addr); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %h want 1", ex_ready); end
        rd_w_addr = 5'd2; addr = 64'h22;
        @(negedge clk);
        ex_valid = 1'b0;
        checks++; if ({wb_valid, wb_data, wb_rd_addr} !== {1'b1, 64'h22, 5'd2}) begin errors++; $display("FAIL b2b_second: valid=%h data=%h rd=%0d want 1 22 2", wb_valid, wb_data, wb_rd_addr); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %h want 0", wb_valid); end
    endtask

`ifndef MEM_MISALIGN_CHECK_EN
    task automatic test_cross_boundary();
        dbus_ready = 1'b1;
        drive_op(1'b0, 1'b1, 1'b0, 8'h0F, 64'h1006, 64'hAABBCCDD, 5'd0, 1'b0);
        checks++; if ({dbus_valid, dbus_addr, dbus_wstrb, dbus_wdata} !== {1'b1, 64'h1000, 8'hC0, 64'hCCDD000000000000}) begin errors++; $display("FAIL sw_cross: valid=%h addr=%h wstrb=%h wdata=%h want 1 1000 c0 ccdd000000000000", dbus_valid, dbus_addr, dbus_wstrb, dbus_wdata); end
        @(negedge clk);
        dbus_ready = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sw_cross_wb: got %h want 1", wb_valid); end
        @(negedge clk);
    endtask
`else
    task automatic test_misalign();
        dbus_ready = 1'b1;
        drive_op(1'b1, 1'b0, 1'b0, 8'h0F, 64'h1002, 64'h0, 5'd6, 1'b1);
        checks++; if (dbus_valid !== 1'b0) begin errors++; $display("FAIL mis_no_dbus: got %h want 0", dbus_valid); end
        checks++; if ({wb_valid, wb_rd_ena, misalign} !== 3'b101) begin errors++; $display("FAIL mis_wb: wb_valid=%h wb_rd_ena=%h misalign=%h want 1 0 1", wb_valid, wb_rd_ena, misalign); end
        @(negedge clk);
        checks++; if ({misalign, wb_valid, dbus_valid, ex_ready} !== 4'b0001) begin errors++; $display("FAIL mis_after: misalign=%h wb_valid=%h dbus_valid=%h ex_ready=%h want 0 0 0 1", misalign, wb_valid, dbus_valid, ex_ready); end
        dbus_ready = 1'b0;
    endtask
`endif

    task automatic test_rst_mid();
        dbus_ready = 1'b1; dbus_rvalid = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 8'hFF, 64'h4000, 64'h0, 5'd5, 1'b1);
        @(negedge clk);
        dbus_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ex_ready_in_rst: got %h want 0", ex_ready); end
        @(negedge clk);
        rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 64'hDEADBEEFCAFEF00D;
        #1;
        checks++; if ({dbus_valid, wb_valid, ex_ready} !== 3'b001) begin errors++; $display("FAIL rstmid_after: dbus_valid=%h wb_valid=%h ex_ready=%h want 0 0 1", dbus_valid, wb_valid, ex_ready); end
        @(negedge clk);
        checks++; if ({wb_valid, ex_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_late_rvalid: wb_valid=%h ex_ready=%h want 0 1", wb_valid, ex_ready); end
        dbus_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_ld();
        test_load_byte();
        test_load_word();
        test_store_stall();
        test_store_fast();
        test_back_to_back();
`ifndef MEM_MISALIGN_CHECK_EN
        test_cross_boundary();
`else
        test_misalign();
`endif
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
